// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  // Default instruction/address width and queue depth.
  localparam int FETCH_WIDTH = 32;
  localparam int FETCH_DEPTH = 4;

  // Byte step between consecutive fetch addresses at the default width.
  localparam int PC_STEP = FETCH_WIDTH / 8;

  // Bits needed to hold an occupancy of 0..DEPTH inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int OCC_W = occ_width(FETCH_DEPTH);

  // One buffered fetch result at the default width.
  typedef struct packed {
    logic [FETCH_WIDTH-1:0] pc;
    logic [FETCH_WIDTH-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a synchronous clear, used as the prefetch
// queue. DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;

  // Pointer and occupancy bookkeeping; clear empties the queue in one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];
  assign count     = cnt;
  assign full      = (cnt == (AW+1)'(DEPTH));
  assign empty     = (cnt == '0);

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues reads to a synchronous
// instruction port, buffers up to DEPTH results and hands them to decode.
// Optional macro FETCH_BYPASS_EN: a response arriving while the queue is
// empty is presented to decode combinationally (redirect latency 1 cycle).
//
// Handshake: an entry transfers on a rising edge where out_valid and
// out_ready are both high; out_valid does not depend on out_ready, and a
// redirect forces out_valid low so nothing transfers in that cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = FETCH_WIDTH,
  parameter int               DEPTH    = FETCH_DEPTH,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_addr,
  output logic [WIDTH-1:0] imem_addr,
  output logic             imem_re,
  input  logic [WIDTH-1:0] imem_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_inst,
  output logic [WIDTH-1:0] out_pc
);

  localparam int               CW   = occ_width(DEPTH);
  localparam logic [WIDTH-1:0] STEP = WIDTH'(WIDTH / 8);

  logic [WIDTH-1:0]   fetch_pc;
  logic [WIDTH-1:0]   inflight_pc;
  logic               inflight;

  logic               q_push;
  logic               q_pop;
  logic [2*WIDTH-1:0] q_head;
  logic               q_full;
  logic               q_empty;
  logic [CW-1:0]      q_count;

  logic               accept;
  logic [CW:0]        pending;

  sync_fifo #(
    .WIDTH (2*WIDTH),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (redirect),
    .push      (q_push),
    .push_data ({inflight_pc, imem_data}),
    .pop       (q_pop),
    .head_data (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

`ifdef FETCH_BYPASS_EN
  // Output mux: queue head when buffered, else the arriving response.
  always_comb begin
    out_valid = rst_n & ~redirect & (~q_empty | inflight);
    out_pc    = q_empty ? inflight_pc : q_head[2*WIDTH-1:WIDTH];
    out_inst  = q_empty ? imem_data   : q_head[WIDTH-1:0];
    accept    = out_valid & out_ready;
    q_pop     = accept & ~q_empty;
    // A bypassed response that decode takes never enters the queue.
    q_push    = inflight & ~redirect & ~(q_empty & accept);
  end
`else
  // Output comes only from the queue head; responses always pass through it.
  always_comb begin
    out_valid = rst_n & ~redirect & ~q_empty;
    out_pc    = q_head[2*WIDTH-1:WIDTH];
    out_inst  = q_head[WIDTH-1:0];
    accept    = out_valid & out_ready;
    q_pop     = accept;
    q_push    = inflight & ~redirect;
  end
`endif

  // Credit check: buffered plus in-flight, less what leaves this cycle,
  // must stay below DEPTH for a new request; a redirect always issues.
  assign pending   = {1'b0, q_count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, accept};
  assign imem_re   = rst_n & (redirect | (pending < (CW+1)'(DEPTH)));
  assign imem_addr = redirect ? redirect_addr : fetch_pc;

  // PC and in-flight tracking; wraps modulo 2^WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= RESET_PC;
      inflight    <= 1'b0;
    end else begin
      inflight <= imem_re;
      if (imem_re) begin
        inflight_pc <= imem_addr;
        fetch_pc    <= imem_addr + STEP;
      end
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(q_push && q_full));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) !(q_pop && q_empty));

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed phases followed by random
// traffic, compared each cycle against a stream-level reference model.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int          WIDTH    = FETCH_WIDTH;
  localparam int          DEPTH    = FETCH_DEPTH;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  // Clock / reset and DUT signals
  logic             clk;
  logic             rst_n;
  logic             redirect;
  logic [WIDTH-1:0] redirect_addr;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_re;
  logic [WIDTH-1:0] imem_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_inst;
  logic [WIDTH-1:0] out_pc;

  fetch_queue #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .imem_addr     (imem_addr),
    .imem_re       (imem_re),
    .imem_data     (imem_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_inst      (out_inst),
    .out_pc        (out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read instruction memory: data is a fixed function of address.
  initial imem_data = '0;
  always @(posedge clk) imem_data <= imem_addr ^ KEY;

  // Scoreboard: PCs issued but not yet delivered, with their issue cycle.
  logic [WIDTH-1:0] exp_q[$];
  int               iss_q[$];
  logic [WIDTH-1:0] next_pc;
  int               cyc;
  int               n_checks;
  int               n_pass;
  int               dut_delivered;
  logic [OCC_W:0]   dut_issues;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then
  // advance the model to what the next edge commits.
  task automatic step(input logic rst, input logic rd, input logic [31:0] ra, input logic rdy);
    logic         exp_valid;
    logic         exp_re;
    int           acc;
    fetch_entry_t head;
    @(negedge clk);
    rst_n         = rst;
    redirect      = rd;
    redirect_addr = ra;
    out_ready     = rdy;
    #1;
    exp_valid = rst && !rd && (exp_q.size() > 0) && (cyc - iss_q[0] >= LAT);
    acc       = (exp_valid && rdy) ? 1 : 0;
    exp_re    = rst && (rd || ((exp_q.size() - acc) < DEPTH));
    check("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
    check("imem_re",   {31'b0, imem_re},   {31'b0, exp_re});
    if (exp_re) check("imem_addr", imem_addr, rd ? ra : next_pc);
    if (exp_valid && out_valid) begin
      head.pc   = exp_q[0];
      head.inst = exp_q[0] ^ KEY;
      check("out_pc",   out_pc,   head.pc);
      check("out_inst", out_inst, head.inst);
    end
    if (out_valid && out_ready) dut_delivered++;
    if (imem_re) dut_issues++;
    if (!rst) begin
      exp_q.delete();
      iss_q.delete();
      next_pc = RESET_PC;
    end else begin
      if (rd) begin
        exp_q.delete();
        iss_q.delete();
      end else if (acc != 0) begin
        void'(exp_q.pop_front());
        void'(iss_q.pop_front());
      end
      if (exp_re) begin
        exp_q.push_back(rd ? ra : next_pc);
        iss_q.push_back(cyc);
        next_pc = (rd ? ra : next_pc) + 32'(PC_STEP);
      end
    end
    cyc++;
  endtask

  initial begin
    logic [31:0] ra;
    n_checks = 0;
    n_pass = 0;
    cyc = 0;
    next_pc = RESET_PC;
    dut_delivered = 0;
    dut_issues = '0;
    rst_n = 1'b0;
    redirect = 1'b0;
    redirect_addr = '0;
    out_ready = 1'b0;

    // Reset, then stream with decode always ready.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1);
    dut_delivered = 0;
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, '0, 1'b1);
    check("stream_latency", 32'(dut_delivered), 32'(12 - LAT));

    // Stall straight after reset: exactly DEPTH requests, then release.
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, '0, 1'b0);
    dut_issues = '0;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0, 1'b0);
    check("stall_issues", 32'(dut_issues), 32'(DEPTH));
    dut_delivered = 0;
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, '0, 1'b1);
    check("throughput", 32'(dut_delivered), 32'd20);

    // Redirect with entries buffered and decode ready in the same cycle.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 32'h0000_0100, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0, 1'b1);

    // Redirect near the top of the address space: PC wraps to zero.
    step(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0, 1'b1);

    // Back-to-back redirects, last one wins; then an unaligned target.
    step(1'b1, 1'b1, 32'h0000_0400, 1'b1);
    step(1'b1, 1'b1, 32'h0000_0800, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b1, 32'h0000_0302, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0, 1'b1);

    // Reset asserted mid-stream with entries queued, then restart.
    step(1'b1, 1'b1, 32'h0000_0200, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0, 1'b1);

    // Random traffic: ready mostly high, occasional redirects.
    for (int i = 0; i < 3000; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 3) != 0) ra = ra & 32'hFFFF_FFFC;
      step(1'b1, ($urandom_range(0, 24) == 0), ra, ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end for the pipelined core: owns the program counter and issues requests to the synchronous-read instruction port. Buffers up to DEPTH fetched instructions with their PCs, and hands them to decode over a valid/ready handshake. Replaces the free-running PC plus single fetch register with backpressure, a prefetch queue and flush-on-redirect.

## Interface
- WIDTH, 32: instruction/address width; PC step is WIDTH/8.
- DEPTH, 4: queue entries; power of two, ≥2.
- RESET_PC, 0: first fetch address after reset.

- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- redirect  in  1  flush queue and restart fetch at redirect_addr (registered jump from execute).
- redirect_addr  in  WIDTH  new fetch address.
- imem_addr  out  WIDTH  instruction-port address.
- imem_re  out  1  instruction-port read strobe.
- imem_data  in  WIDTH  read data, valid the cycle after the strobe was sampled.
- out_valid  out  1  head entry valid.
- out_ready  in  1  decode accepts head.
- out_inst  out  WIDTH  head instruction.
- out_pc  out  WIDTH  head PC.

## Operation
- State: fetch_pc, inflight flag + inflight_pc, queue (pc, inst), occupancy count.
- Reset (async assert): fetch_pc=RESET_PC, queue empty, inflight=0; out_valid=0, imem_re=0 while rst_n low. out_inst/out_pc don't-care when out_valid=0.
- Issue: imem_re=1 when occupancy + inflight − pop < DEPTH, where pop = out_valid & out_ready from the queue. imem_addr = redirect ? redirect_addr : fetch_pc. On issue: inflight<=1, inflight_pc<=imem_addr, fetch_pc<=imem_addr+WIDTH/8. Arithmetic is modulo 2^WIDTH; 0xFFFF_FFFC+4 wraps to 0.
- Response: when inflight=1, the {inflight_pc, imem_data} pair is pushed at the next edge. Push and pop in the same cycle are legal; occupancy is unchanged.
- Overflow and underflow are impossible by the credit rule; assertions flag push-when-full and pop-when-empty.
- Redirect (priority over everything):
  - Queue cleared and the pending response discarded.
  - out_valid forced 0 in the redirect cycle; a simultaneous out_ready is ignored.
  - A request to redirect_addr is issued in the same cycle. fetch_pc<=redirect_addr+WIDTH/8.
  - Back-to-back redirects: the last one wins.
- Non-aligned redirect_addr is passed through unchanged.

## Timing
- Redirect at cycle 0 → imem_re/imem_addr in cycle 0 → imem_data in cycle 1 → out_valid in cycle 2 (cycle 1 with bypass).
- Sustained throughput is 1 instruction/cycle with out_ready held high, for every legal DEPTH including 2.
- With out_ready low, at most DEPTH entries are buffered, then imem_re drops. It reasserts in the cycle out_ready pops.
- Reset deassertion: first request issued in the first cycle with rst_n high.

## Configuration
- FETCH_BYPASS_EN defined: when the queue is empty and a response arrives, it drives out_valid/out_inst/out_pc combinationally. If accepted, it is not written to the queue; otherwise it is pushed. Redirect latency is 1 cycle.
- FETCH_BYPASS_EN undefined: all responses pass through the queue; redirect latency is 2 cycles; no imem_data→out_* combinational path.

## Structure
- Package fetch_pkg: fetch_entry_t (pc, inst at the default width), the PC-step constant, and a clog2-derived occupancy-width constant.
- Sub-module sync_fifo: WIDTH/DEPTH parameters, push/pop/clear, full/empty/count outputs, async active-low reset.
- fetch_queue holds the PC, the in-flight tracking, the credit check and the bypass mux.

## Test plan
- Reset, out_ready=1, memory returning inst=addr^0xA5A5_0000 → out_pc 0,4,8,… one per cycle from cycle 2; imem_re never drops.
- out_ready=0 for 10 cycles, DEPTH=4 → exactly 4 issues, then imem_re=0; release → PCs 0,4,8,12,16 in order, no gaps or duplicates.
- Redirect to 0x100 while queue holds 3 entries and one in flight → out_valid=0 in cycle 0, then next out_pc=0x100; stale PCs never appear.
- Redirect with out_valid & out_ready in the same cycle → head not consumed; next delivered PC = redirect_addr.
- redirect_addr=0xFFFF_FFF8, WIDTH=32 → out_pc sequence FFFF_FFF8, FFFF_FFFC, 0, 4.
- rst_n asserted mid-stream with 2 entries queued → out_valid and imem_re low immediately; after release, fetch restarts at RESET_PC. Run with and without FETCH_BYPASS_EN (latency 1 vs 2).
